// File: rtl/fru_pkg.sv
// Shared types for the FRU timed filter unit: per-bit mode encoding, FSM
// states and the per-bit filter function.
package fru_pkg;

  typedef enum logic [1:0] {
    SFU_PASS   = 2'b00,
    SFU_CONST  = 2'b01,
    SFU_FREEZE = 2'b10,
    SFU_INVERT = 2'b11
  } fru_sfu_mode_e;

  typedef enum logic {
    TFU_IDLE   = 1'b0,
    TFU_ACTIVE = 1'b1
  } fru_tfu_state_e;

  // Filtered value of one channel while the window is open.
  function automatic logic sfu_apply(input fru_sfu_mode_e mode, input logic q,
                                     input logic cval, input logic fval);
    logic r;
    case (mode)
      SFU_PASS:   r = q;
      SFU_CONST:  r = cval;
      SFU_FREEZE: r = fval;
      SFU_INVERT: r = ~q;
      default:    r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fru_tfu_window_ctr.sv
// Window-length counter: load / decrement / clear.
// A loaded value of 0 means a sticky window (counter parked at 0).
module fru_tfu_window_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire,
  output logic             o_sticky
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over load, load wins over decrement; never wraps below 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                   r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_expire = (r_cnt == CNT_W'(1));
  assign o_sticky = (r_cnt == '0);

endmodule

// File: rtl/fru_timed_filter_unit.sv
// Trigger-armed, time-windowed per-bit override stage.
// Optional feature macro: FRU_TFU_RETRIGGER_EN (Trigger during an open window
// reloads the window and re-latches the configuration; Done suppressed then).
module fru_timed_filter_unit
  import fru_pkg::*;
#(
  parameter int FILTER_SIZE = 10,
  parameter int CNT_W       = 8
) (
  input  logic                     Clk,
  input  logic                     RstN,
  input  logic                     FruEn,
  input  logic                     Trigger,
  input  logic [2*FILTER_SIZE-1:0] ModeCfg,
  input  logic [FILTER_SIZE-1:0]   RegConst,
  input  logic [CNT_W-1:0]         HoldCycles,
  input  logic [FILTER_SIZE-1:0]   Qin,
  output logic [FILTER_SIZE-1:0]   Qout,
  output logic                     Active,
  output logic                     Done
);

  fru_tfu_state_e r_state, w_state_nxt;
  logic [FILTER_SIZE-1:0][1:0] r_mode;
  logic [FILTER_SIZE-1:0]      r_const;
  logic [FILTER_SIZE-1:0]      r_frz;
  logic                        r_done;
  logic                        w_load, w_dec, w_clr, w_done_nxt;
  logic                        w_expire, w_sticky;
  logic                        w_win;
  logic [FILTER_SIZE-1:0]      w_filt;

  fru_tfu_window_ctr #(.CNT_W(CNT_W)) u_ctr (
    .i_clk      (Clk),
    .i_rst_n    (RstN),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (HoldCycles),
    .i_dec      (w_dec),
    .o_expire   (w_expire),
    .o_sticky   (w_sticky)
  );

  // State, Done pulse register.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state <= TFU_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state and counter control; FruEn low aborts from any state without Done.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_clr       = 1'b0;
    w_done_nxt  = 1'b0;
    if (!FruEn) begin
      w_state_nxt = TFU_IDLE;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        TFU_IDLE: begin
          if (Trigger) begin
            w_state_nxt = TFU_ACTIVE;
            w_load      = 1'b1;
          end
        end
        TFU_ACTIVE: begin
`ifdef FRU_TFU_RETRIGGER_EN
          if (Trigger) begin
            w_load = 1'b1;
          end else
`endif
          begin
            w_dec = !w_sticky;
            if (w_expire) begin
              w_state_nxt = TFU_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: w_state_nxt = TFU_IDLE;
      endcase
    end
  end

  // Configuration and freeze snapshot, captured only on a (re)trigger edge.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_mode  <= '0;
      r_const <= '0;
      r_frz   <= '0;
    end else if (w_load) begin
      r_mode  <= ModeCfg;
      r_const <= RegConst;
      r_frz   <= Qin;
    end
  end

  for (genvar i = 0; i < FILTER_SIZE; i++) begin : g_bit
    assign w_filt[i] = sfu_apply(fru_sfu_mode_e'(r_mode[i]), Qin[i], r_const[i], r_frz[i]);
  end

  // FruEn gates the window combinationally so an abort is visible in the same cycle.
  assign w_win  = (r_state == TFU_ACTIVE) && FruEn;
  assign Qout   = w_win ? w_filt : Qin;
  assign Active = (r_state == TFU_ACTIVE);
  assign Done   = r_done;

endmodule

// File: tb/tb_fru_timed_filter_unit.sv
// Directed self-checking bench for fru_timed_filter_unit.
module tb_fru_timed_filter_unit;

  logic        Clk, RstN, FruEn, Trigger;
  logic [19:0] ModeCfg;
  logic [9:0]  RegConst, Qin, Qout;
  logic [7:0]  HoldCycles;
  logic        Active, Done;

  int n_tests = 0;
  int n_fail  = 0;

  fru_timed_filter_unit #(.FILTER_SIZE(10), .CNT_W(8)) dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .FruEn      (FruEn),
    .Trigger    (Trigger),
    .ModeCfg    (ModeCfg),
    .RegConst   (RegConst),
    .HoldCycles (HoldCycles),
    .Qin        (Qin),
    .Qout       (Qout),
    .Active     (Active),
    .Done       (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge: start of a new cycle.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Expected FREEZE(ch0, captured 1)/INVERT(ch1)/PASS(rest) outputs, hand-derived.
  logic [9:0] mix_in  [4] = '{10'h2AA, 10'h155, 10'h2AA, 10'h155};
  logic [9:0] mix_exp [4] = '{10'h2A9, 10'h157, 10'h2A9, 10'h157};

  initial begin
    int act_cnt, done_cnt, bad_act, bad_done;
    RstN = 1'b0; FruEn = 1'b0; Trigger = 1'b0;
    ModeCfg = '0; RegConst = '0; HoldCycles = '0; Qin = 10'h3A5;
    #2;
    // 1 reset
    chk("rst_qout",   Qout,   10'h3A5);
    chk("rst_active", Active, 0);
    chk("rst_done",   Done,   0);
    #20 RstN = 1'b1;
    FruEn = 1'b1;
    tick;

    // 2 CONST window, config changes mid-window are ignored
    ModeCfg = 20'h55555; RegConst = 10'h0F0; HoldCycles = 8'd3;
    Trigger = 1'b1; Qin = 10'h3A5;
    #1 chk("c_trig_qout", Qout, 10'h3A5);
    tick; Trigger = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      Qin = 10'h100 + 10'(k);
      if (k == 2) begin ModeCfg = '0; RegConst = 10'h3FF; end
      #1;
      chk($sformatf("c_win%0d_qout", k), Qout, 10'h0F0);
      chk($sformatf("c_win%0d_act", k),  Active, 1);
      chk($sformatf("c_win%0d_done", k), Done, 0);
      tick;
    end
    Qin = 10'h222;
    #1;
    chk("c_end_qout", Qout,   10'h222);
    chk("c_end_act",  Active, 0);
    chk("c_end_done", Done,   1);
    tick;
    chk("c_post_done", Done, 0);

    // 3 FREEZE ch0 / INVERT ch1 / PASS rest, Qin toggling
    ModeCfg = 20'h0000E; HoldCycles = 8'd4;
    Trigger = 1'b1; Qin = 10'h155;
    tick; Trigger = 1'b0;
    for (int k = 0; k < 4; k++) begin
      Qin = mix_in[k];
      #1 chk($sformatf("m_win%0d_qout", k), Qout, mix_exp[k]);
      tick;
    end
    chk("m_end_done", Done, 1);

    // 4 abort by FruEn in window cycle 4
    ModeCfg = 20'h55555; RegConst = 10'h00F; HoldCycles = 8'd10;
    Trigger = 1'b1; Qin = 10'h300;
    tick; Trigger = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1 chk($sformatf("a_win%0d_qout", k), Qout, 10'h00F);
      tick;
    end
    FruEn = 1'b0; Qin = 10'h2C3;
    #1;
    chk("a_abort_qout", Qout,   10'h2C3);
    chk("a_abort_act",  Active, 1);
    tick; FruEn = 1'b1;
    #1;
    chk("a_post_act",  Active, 0);
    chk("a_post_qout", Qout,   10'h2C3);
    bad_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (Done) bad_done++;
      tick;
    end
    chk("a_no_done", bad_done, 0);

    // Trigger while disabled is ignored
    FruEn = 1'b0; Trigger = 1'b1;
    tick; Trigger = 1'b0; FruEn = 1'b1;
    #1 chk("dis_trig_act", Active, 0);

    // 5 sticky window
    HoldCycles = 8'd0; Trigger = 1'b1;
    tick; Trigger = 1'b0;
    bad_act = 0; bad_done = 0;
    for (int k = 0; k < 300; k++) begin
      if (!Active) bad_act++;
      if (Done)    bad_done++;
      tick;
    end
    chk("s_active_held", bad_act,  0);
    chk("s_no_done",     bad_done, 0);
    FruEn = 1'b0;
    tick; FruEn = 1'b1;
    #1;
    chk("s_end_act",  Active, 0);
    chk("s_end_done", Done,   0);

    // 6 retrigger in window cycle 3
    HoldCycles = 8'd4; Trigger = 1'b1;
    tick; Trigger = 1'b0;
    act_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (Active) act_cnt++;
      if (Done)   done_cnt++;
      Trigger = (k == 3);
      tick;
      Trigger = 1'b0;
    end
`ifdef FRU_TFU_RETRIGGER_EN
    chk("r_window_len", act_cnt, 7);
`else
    chk("r_window_len", act_cnt, 4);
`endif
    chk("r_done_cnt", done_cnt, 1);

    // async reset in the middle of a window
    HoldCycles = 8'd5; ModeCfg = 20'hFFFFF; Trigger = 1'b1; Qin = 10'h0A5;
    tick; Trigger = 1'b0;
    #1 chk("ar_win_qout", Qout, 10'h35A);
    #2 RstN = 1'b0;
    #1;
    chk("ar_qout", Qout,   10'h0A5);
    chk("ar_act",  Active, 0);
    RstN = 1'b1;
    tick;
    #1 chk("ar_post_qout", Qout, 10'h0A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
